mipi_capture_ctrl: RTL and testbench

- Sequences capture from the CSI-2 deserializer pixel stream (img_clk domain).
- Waits for PHY lock, then enables the deserializer. Arms on a clean frame boundary and gates exactly N whole frames (or runs continuously) through to downstream.
- Counts frames, lines and pixels per line, and raises sticky error flags on watchdog timeout or lock loss.

---
 rtl/mipi_capture_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mipi_capture_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_capture_ctrl.sv
// mipi_capture_ctrl: sequences capture from the CSI-2 deserializer pixel stream.
// Waits for PHY lock, enables the deserializer, arms on a clean frame boundary
// and gates N whole frames (or runs until stop) through to the cap_* outputs.
// Frame/line/pixel counters and sticky timeout/lock-loss flags for software.
//
// Handshake note: the des_* and cap_* streams are plain qualifier buses with
// no back-pressure. A pixel is transferred on every cycle its dvo is high, and
// lvo/fvo frame it. cap_* is des_* delayed by two cycles, forced to 0 while
// gated off. start/stop are single-cycle request pulses: start is accepted
// only in IDLE, and stop is ignored in IDLE.
module mipi_capture_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int WDOG_W     = 24
) (
  input  logic                  img_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            num_frames,
  input  logic [WDOG_W-1:0]     timeout_cycles,
  input  logic                  locked,
  output logic                  des_enable,
  input  logic [DATA_WIDTH-1:0] des_dat,
  input  logic                  des_dvo,
  input  logic                  des_lvo,
  input  logic                  des_fvo,
  output logic [DATA_WIDTH-1:0] cap_dat,
  output logic                  cap_dvo,
  output logic                  cap_lvo,
  output logic                  cap_fvo,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  lock_err,
  output logic [7:0]            frame_count,
  output logic [15:0]           lines_last,
  output logic [15:0]           pixels_last,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_ARM       = 3'd2,
    S_CAPTURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t state, state_nx;

  logic                  lock_meta, lock_s;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  dvo_q, lvo_q, fvo_q, lvo_qq, fvo_qq;
  logic                  rise_f, fall_f, rise_l, fall_l;
  logic                  armed, stop_pend;
  logic [WDOG_W-1:0]     wdog_cnt;
  logic                  wdog_exp;
  logic [15:0]           line_cnt, pix_cnt;
  logic                  pass, last_frame;
  logic                  run_clear, frame_done, set_tmo, set_lerr, set_spend;

  assign rise_f = fvo_q & ~fvo_qq;
  assign fall_f = ~fvo_q & fvo_qq;
  assign rise_l = lvo_q & ~lvo_qq;
  assign fall_l = ~lvo_q & lvo_qq;

  // The ARM cycle that sees the first clean frame start already belongs to the run.
  assign pass       = (state == S_CAPTURE) | ((state == S_ARM) & rise_f & armed);
  assign wdog_exp   = (timeout_cycles != '0) && (wdog_cnt >= timeout_cycles);
  assign last_frame = (num_frames != 8'd0) && ((frame_count + 8'd1) == num_frames);

  assign des_enable = (state == S_ARM) | (state == S_CAPTURE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign state_dbg  = state;

  // Two-flop synchronizer for the asynchronous PHY lock.
  always_ff @(posedge img_clk or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  // Input pipeline: stage q feeds the output path, stage qq forms the edges.
  always_ff @(posedge img_clk or posedge reset) begin
    if (reset) begin
      dat_q  <= '0;
      dvo_q  <= 1'b0;
      lvo_q  <= 1'b0;
      fvo_q  <= 1'b0;
      lvo_qq <= 1'b0;
      fvo_qq <= 1'b0;
    end else begin
      dat_q  <= des_dat;
      dvo_q  <= des_dvo;
      lvo_q  <= des_lvo;
      fvo_q  <= des_fvo;
      lvo_qq <= lvo_q;
      fvo_qq <= fvo_q;
    end
  end

  // Gated output path; everything reads 0 while the run is not passing data.
  always_ff @(posedge img_clk or posedge reset) begin
    if (reset) begin
      cap_dat <= '0;
      cap_dvo <= 1'b0;
      cap_lvo <= 1'b0;
      cap_fvo <= 1'b0;
    end else if (pass) begin
      cap_dat <= dat_q;
      cap_dvo <= dvo_q;
      cap_lvo <= lvo_q;
      cap_fvo <= fvo_q;
    end else begin
      cap_dat <= '0;
      cap_dvo <= 1'b0;
      cap_lvo <= 1'b0;
      cap_fvo <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge img_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM next state and run events. A completing frame takes priority over
  // watchdog expiry, and it is still counted when lock drops on the same cycle.
  always_comb begin
    state_nx   = state;
    run_clear  = 1'b0;
    frame_done = 1'b0;
    set_tmo    = 1'b0;
    set_lerr   = 1'b0;
    set_spend  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx  = S_WAIT_LOCK;
          run_clear = 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (stop) begin
          state_nx = S_DONE;
        end else if (wdog_exp) begin
          set_tmo  = 1'b1;
          state_nx = S_DONE;
        end else if (lock_s) begin
          state_nx = S_ARM;
        end
      end
      S_ARM: begin
        if (!lock_s) begin
          set_lerr = 1'b1;
          state_nx = S_DONE;
        end else if (stop) begin
          state_nx = S_DONE;
        end else if (wdog_exp) begin
          set_tmo  = 1'b1;
          state_nx = S_DONE;
        end else if (rise_f && armed) begin
          state_nx = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (stop) set_spend = 1'b1;
        if (fall_f) begin
          frame_done = 1'b1;
          if (!lock_s) begin
            set_lerr = 1'b1;
            state_nx = S_DONE;
          end else if (stop_pend || stop || last_frame) begin
            state_nx = S_DONE;
          end
        end else if (!lock_s) begin
          set_lerr = 1'b1;
          state_nx = S_DONE;
        end else if (wdog_exp) begin
          set_tmo  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Run bookkeeping: armed, pending stop, sticky errors and frame results.
  always_ff @(posedge img_clk or posedge reset) begin
    if (reset) begin
      armed       <= 1'b0;
      stop_pend   <= 1'b0;
      timeout_err <= 1'b0;
      lock_err    <= 1'b0;
      frame_count <= 8'd0;
      lines_last  <= 16'd0;
    end else begin
      if (state == S_WAIT_LOCK && state_nx == S_ARM) armed <= 1'b0;
      else if (state == S_ARM && !fvo_q)              armed <= 1'b1;

      if (run_clear)      stop_pend <= 1'b0;
      else if (set_spend) stop_pend <= 1'b1;

      if (run_clear)    timeout_err <= 1'b0;
      else if (set_tmo) timeout_err <= 1'b1;

      if (run_clear)     lock_err <= 1'b0;
      else if (set_lerr) lock_err <= 1'b1;

      if (run_clear) begin
        frame_count <= 8'd0;
      end else if (frame_done) begin
        frame_count <= frame_count + 8'd1;
        lines_last  <= line_cnt;
      end
    end
  end

  // Watchdog: restarts on every state change and on any frame-valid edge.
  always_ff @(posedge img_clk or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if ((state_nx != state) || rise_f || fall_f) begin
      wdog_cnt <= '0;
    end else if ((state == S_WAIT_LOCK || state == S_ARM || state == S_CAPTURE) &&
                 (wdog_cnt != '1)) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  // Line and pixel counters, saturating, active only while the run passes data.
  always_ff @(posedge img_clk or posedge reset) begin
    if (reset) begin
      line_cnt    <= 16'd0;
      pix_cnt     <= 16'd0;
      pixels_last <= 16'd0;
    end else if (pass) begin
      if (rise_f)                          line_cnt <= rise_l ? 16'd1 : 16'd0;
      else if (rise_l && line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;

      if (rise_l)                          pix_cnt <= dvo_q ? 16'd1 : 16'd0;
      else if (dvo_q && pix_cnt != 16'hFFFF)   pix_cnt <= pix_cnt + 16'd1;

      if (fall_l) pixels_last <= pix_cnt;
    end
  end

endmodule

// File: tb/tb_mipi_capture_ctrl.sv
// Testbench for mipi_capture_ctrl: drives synthetic CSI-2 frames, predicts the
// pixels that must appear on cap_* and checks run control, counters and errors.
module tb_mipi_capture_ctrl;

  localparam int DW = 10;
  localparam int WW = 24;

  logic          img_clk = 1'b0;
  logic          reset;
  logic          start, stop, locked;
  logic [7:0]    num_frames;
  logic [WW-1:0] timeout_cycles;
  logic          des_enable;
  logic [DW-1:0] des_dat;
  logic          des_dvo, des_lvo, des_fvo;
  logic [DW-1:0] cap_dat;
  logic          cap_dvo, cap_lvo, cap_fvo;
  logic          busy, done, timeout_err, lock_err;
  logic [7:0]    frame_count;
  logic [15:0]   lines_last, pixels_last;
  logic [2:0]    state_dbg;

  mipi_capture_ctrl #(.DATA_WIDTH(DW), .WDOG_W(WW)) dut (
    .img_clk(img_clk), .reset(reset), .start(start), .stop(stop),
    .num_frames(num_frames), .timeout_cycles(timeout_cycles), .locked(locked),
    .des_enable(des_enable), .des_dat(des_dat), .des_dvo(des_dvo),
    .des_lvo(des_lvo), .des_fvo(des_fvo), .cap_dat(cap_dat), .cap_dvo(cap_dvo),
    .cap_lvo(cap_lvo), .cap_fvo(cap_fvo), .busy(busy), .done(done),
    .timeout_err(timeout_err), .lock_err(lock_err), .frame_count(frame_count),
    .lines_last(lines_last), .pixels_last(pixels_last), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 img_clk = ~img_clk;

  int cyc = 0;
  always @(posedge img_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: sim time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  done_cnt = 0;
  int  last_done_cyc = 0;
  bit  sb_off = 1'b0;
  bit  lat_arm = 1'b0;
  int  cap_first_cyc = 0;
  bit  rec_first = 1'b0;
  int  first_dvo_cyc = 0;
  int  fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge img_clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (cap_dvo && lat_arm) begin
        cap_first_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (!sb_off && cap_dvo) begin
        if (exp_q.size() > 0) check("cap_dat", 32'(cap_dat), 32'(exp_q.pop_front()));
        else                  check("cap_extra", 32'(cap_dvo), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge img_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic drive_line(input int pix, input bit exp_pass, input bit do_stop);
    des_lvo = 1'b1;
    for (int p = 0; p < pix; p++) begin
      des_dvo = 1'b1;
      des_dat = DW'($urandom_range(1, 1023));
      if (exp_pass) exp_q.push_back(des_dat);
      if (p == 0 && do_stop) stop = 1'b1;
      if (rec_first) begin
        first_dvo_cyc = cyc;
        rec_first = 1'b0;
      end
      tick(1);
      stop = 1'b0;
    end
    des_lvo = 1'b0;
    des_dvo = 1'b0;
    des_dat = '0;
    tick(2);
  endtask

  task automatic send_frame(input int lines, input int pix, input bit exp_pass, input int stop_line);
    des_fvo = 1'b1;
    tick(2);
    for (int l = 0; l < lines; l++) drive_line(pix, exp_pass, l == stop_line);
    des_fvo = 1'b0;
    fall_cyc = cyc;
    tick(4);
  endtask

  task automatic wait_done(input int prev, input int budget, input string tag);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(done_cnt > prev), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int d0, t0;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; locked = 1'b0;
    num_frames = 8'd0; timeout_cycles = '0;
    des_dat = '0; des_dvo = 1'b0; des_lvo = 1'b0; des_fvo = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_des_enable", 32'(des_enable), 32'd0);
    check("rst_cap_fvo", 32'(cap_fvo), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_errs", 32'({timeout_err, lock_err, done}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    tick(3);

    // Lock handshake, two frames of 4 lines x 8 pixels.
    num_frames = 8'd2;
    d0 = done_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    tick(49);
    check("t1_en_prelock", 32'(des_enable), 32'd0);
    locked = 1'b1;
    tick(2);
    check("t1_en_sync", 32'(des_enable), 32'd0);
    tick(1);
    check("t1_en_lock", 32'(des_enable), 32'd1);
    tick(3);
    send_frame(4, 8, 1'b1, -1);
    send_frame(4, 8, 1'b1, -1);
    wait_done(d0, 50, "t1_done");
    tick(2);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_frame_count", 32'(frame_count), 32'd2);
    check("t1_lines_last", 32'(lines_last), 32'd4);
    check("t1_pixels_last", 32'(pixels_last), 32'd8);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Mid-frame arm: the partial frame must be dropped.
    num_frames = 8'd1;
    d0 = done_cnt;
    des_fvo = 1'b1;
    tick(2);
    pulse_start();
    for (int l = 0; l < 3; l++) drive_line(8, 1'b0, 1'b0);
    des_fvo = 1'b0;
    tick(4);
    check("t2_busy_armed", 32'(busy), 32'd1);
    lat_arm = 1'b1;
    rec_first = 1'b1;
    send_frame(3, 6, 1'b1, -1);
    wait_done(d0, 50, "t2_done");
    tick(2);
    check("t2_latency", 32'(cap_first_cyc - first_dvo_cyc), 32'd2);
    check("t2_frame_count", 32'(frame_count), 32'd1);
    check("t2_lines_last", 32'(lines_last), 32'd3);
    check("t2_pixels_last", 32'(pixels_last), 32'd6);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Continuous run, stop during frame 3.
    num_frames = 8'd0;
    d0 = done_cnt;
    pulse_start();
    tick(5);
    send_frame(2, 5, 1'b1, -1);
    send_frame(2, 5, 1'b1, -1);
    check("t3_running", 32'(busy), 32'd1);
    send_frame(3, 4, 1'b1, 1);
    wait_done(d0, 50, "t3_done");
    check("t3_done_lat", 32'((last_done_cyc - fall_cyc) >= 1 && (last_done_cyc - fall_cyc) <= 3), 32'd1);
    send_frame(2, 4, 1'b0, -1);
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);
    check("t3_frame_count", 32'(frame_count), 32'd3);
    check("t3_lines_last", 32'(lines_last), 32'd3);
    check("t3_pixels_last", 32'(pixels_last), 32'd4);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Watchdog timeout with no frames after arm.
    timeout_cycles = 24'd100;
    d0 = done_cnt;
    t0 = cyc;
    pulse_start();
    wait_done(d0, 300, "t4_done");
    check("t4_done_time", 32'((last_done_cyc - t0) >= 95 && (last_done_cyc - t0) <= 110), 32'd1);
    tick(2);
    check("t4_timeout_err", 32'(timeout_err), 32'd1);
    check("t4_lock_err", 32'(lock_err), 32'd0);
    check("t4_des_enable", 32'(des_enable), 32'd0);
    timeout_cycles = '0;
    d0 = done_cnt;
    pulse_start();
    check("t4_err_cleared", 32'(timeout_err), 32'd0);
    tick(4);
    check("t4_armed_en", 32'(des_enable), 32'd1);
    pulse_stop();
    wait_done(d0, 10, "t4_stop_done");
    tick(2);
    check("t4_stop_idle", 32'(busy), 32'd0);

    // Lock loss mid-line.
    sb_off = 1'b1;
    num_frames = 8'd0;
    d0 = done_cnt;
    pulse_start();
    tick(5);
    des_fvo = 1'b1;
    tick(2);
    des_lvo = 1'b1;
    des_dvo = 1'b1;
    des_dat = DW'(10'h155);
    tick(4);
    check("t5_cap_live", 32'(cap_dvo), 32'd1);
    locked = 1'b0;
    tick(4);
    check("t5_cap_zero", 32'({cap_fvo, cap_lvo, cap_dvo}), 32'd0);
    check("t5_cap_dat_zero", 32'(cap_dat), 32'd0);
    check("t5_lock_err", 32'(lock_err), 32'd1);
    check("t5_done", 32'(done_cnt - d0), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    des_fvo = 1'b0; des_lvo = 1'b0; des_dvo = 1'b0; des_dat = '0;
    locked = 1'b1;
    tick(6);

    // Async reset mid-capture.
    d0 = done_cnt;
    pulse_start();
    tick(5);
    des_fvo = 1'b1;
    tick(2);
    des_lvo = 1'b1;
    des_dvo = 1'b1;
    des_dat = DW'(10'h2AA);
    tick(3);
    check("t6_capturing", 32'(cap_dvo), 32'd1);
    @(negedge img_clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_cap", 32'({cap_fvo, cap_lvo, cap_dvo}), 32'd0);
    check("t6_rst_busy", 32'({busy, des_enable}), 32'd0);
    check("t6_rst_counts", 32'({lines_last, pixels_last}), 32'd0);
    check("t6_rst_state", 32'(state_dbg), 32'd0);
    des_fvo = 1'b0; des_lvo = 1'b0; des_dvo = 1'b0; des_dat = '0;
    @(negedge img_clk);
    reset = 1'b0;
    tick(3);
    check("t6_post_state", 32'(state_dbg), 32'd0);
    check("t6_post_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
